// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter_if
//  Description : Bundle of the two client ports (A: video read, B: CPU r/w)
//                and the SDRAM controller side of the slot arbiter.
//                slave  = arbiter view, master = clients/controller view.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_arbiter_if;
  // port A (read-only)
  logic        a_req;
  logic [19:0] a_addr;
  logic        a_ack;
  logic        a_valid;
  logic [15:0] a_data;
  // port B (read/write)
  logic        b_req;
  logic        b_we;
  logic [19:0] b_addr;
  logic [15:0] b_din;
  logic [1:0]  b_ds;
  logic        b_ack;
  logic        b_valid;
  logic [15:0] b_data;
  // controller side
  logic        mem_sync;
  logic        mem_oe;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic [15:0] mem_dout;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_din, b_ds, mem_dout,
    output a_ack, a_valid, a_data, b_ack, b_valid, b_data,
           mem_sync, mem_oe, mem_we, mem_addr, mem_din, mem_ds
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_din, b_ds, mem_dout,
    input  a_ack, a_valid, a_data, b_ack, b_valid, b_data,
           mem_sync, mem_oe, mem_we, mem_addr, mem_din, mem_ds
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter
//  Description : Two-port slot arbiter/sequencer for an 8-clock-per-access
//                SDRAM controller. One access per 8-clock slot, idle slots
//                become auto-refresh, power-up quiet period and a cap on
//                consecutive busy slots keep refresh from being starved.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_arbiter #(
  parameter int INIT_SLOTS  = 32,
  parameter int REFRESH_MAX = 48,
  parameter int DATA_PHASE  = 7
) (
  input  logic           clk,
  input  logic           resetn,
  sdram_arbiter_if.slave bus
);

  localparam int c_INIT_W = $clog2(INIT_SLOTS + 1);
  localparam int c_BUSY_W = $clog2(REFRESH_MAX + 1);
  localparam logic [c_INIT_W-1:0] c_INIT_LOAD = c_INIT_W'(INIT_SLOTS);
  localparam logic [c_BUSY_W-1:0] c_BUSY_MAX  = c_BUSY_W'(REFRESH_MAX);
  localparam logic [2:0]          c_PH_LAST   = 3'd7;
  localparam logic [2:0]          c_PH_DATA   = 3'(DATA_PHASE);

  // Who owns the current slot; NONE means the controller refreshes.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  logic [2:0]          r_ph;
  logic [c_INIT_W-1:0] r_init_cnt;
  logic [c_BUSY_W-1:0] r_busy_cnt;
  logic                r_b_lost;
  owner_t              r_owner;

  logic                r_sync;
  logic                r_mem_oe;
  logic                r_mem_we;
  logic [19:0]         r_mem_addr;
  logic [15:0]         r_mem_din;
  logic [1:0]          r_mem_ds;
  logic                r_a_ack;
  logic                r_b_ack;
  logic                r_a_valid;
  logic                r_b_valid;
  logic [15:0]         r_a_data;
  logic [15:0]         r_b_data;

  logic                w_boundary;
  logic                w_grant_a;
  logic                w_grant_b;
  logic [c_INIT_W-1:0] w_init_nxt;
  logic [c_BUSY_W-1:0] w_busy_nxt;
  logic                w_b_lost_nxt;
  owner_t              w_owner_nxt;
  logic [2:0]          w_ph_nxt;
  logic                w_rd_done;
  logic [15:0]         w_rd_word;

  assign w_boundary = (r_ph == c_PH_LAST);
  assign w_ph_nxt   = r_ph + 3'd1;
  // a read slot completes on the edge that closes the slot
  assign w_rd_done  = w_boundary && r_mem_oe;

  // Read data source: sample directly when the data phase is the last one,
  // otherwise hold the captured word until the slot boundary so the client
  // data only changes together with its valid pulse.
  generate
    if (DATA_PHASE == 7) begin : g_direct
      assign w_rd_word = bus.mem_dout;
    end else begin : g_capture
      logic [15:0] r_cap;
      // capture controller read data at the end of the data phase
      always_ff @(posedge clk) begin
        if (!resetn)
          r_cap <= 16'd0;
        else if (r_ph == c_PH_DATA)
          r_cap <= bus.mem_dout;
      end
      assign w_rd_word = r_cap;
    end
  endgenerate

  // Slot decision: quiet period, refresh cap, then fair A/B arbitration.
  always_comb begin
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_init_nxt   = r_init_cnt;
    w_busy_nxt   = r_busy_cnt;
    w_b_lost_nxt = r_b_lost;
    w_owner_nxt  = r_owner;
    if (w_boundary) begin
      w_owner_nxt = OWN_NONE;
      if (r_init_cnt != '0) begin
        w_init_nxt = r_init_cnt - 1'b1;
      end else if (r_busy_cnt == c_BUSY_MAX) begin
        w_busy_nxt = '0;
      end else begin
        if (bus.a_req && bus.b_req) begin
          w_grant_b = r_b_lost;
          w_grant_a = ~r_b_lost;
        end else begin
          w_grant_a = bus.a_req;
          w_grant_b = bus.b_req;
        end
        // B is owed the next contended slot whenever it just lost one
        w_b_lost_nxt = bus.a_req && bus.b_req && w_grant_a;
        if (w_grant_a) begin
          w_owner_nxt = OWN_A;
          w_busy_nxt  = r_busy_cnt + 1'b1;
        end else if (w_grant_b) begin
          w_owner_nxt = OWN_B;
          w_busy_nxt  = r_busy_cnt + 1'b1;
        end else begin
          w_busy_nxt  = '0;
        end
      end
    end
  end

  // Phase counter, slot state, controller command and client responses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ph       <= c_PH_LAST;
      r_init_cnt <= c_INIT_LOAD;
      r_busy_cnt <= '0;
      r_b_lost   <= 1'b0;
      r_owner    <= OWN_NONE;
      r_sync     <= 1'b0;
      r_mem_oe   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 20'd0;
      r_mem_din  <= 16'd0;
      r_mem_ds   <= 2'b00;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_a_data   <= 16'd0;
      r_b_data   <= 16'd0;
    end else begin
      r_ph       <= w_ph_nxt;
      r_sync     <= ~w_ph_nxt[2];
      r_init_cnt <= w_init_nxt;
      r_busy_cnt <= w_busy_nxt;
      r_b_lost   <= w_b_lost_nxt;
      r_owner    <= w_owner_nxt;
      r_a_ack    <= w_grant_a;
      r_b_ack    <= w_grant_b;
      r_a_valid  <= w_rd_done && (r_owner == OWN_A);
      r_b_valid  <= w_rd_done && (r_owner == OWN_B);
      if (w_rd_done && (r_owner == OWN_A))
        r_a_data <= w_rd_word;
      if (w_rd_done && (r_owner == OWN_B))
        r_b_data <= w_rd_word;
      if (w_boundary) begin
        // command is latched once and held for the whole slot
        r_mem_oe <= w_grant_a || (w_grant_b && !bus.b_we);
        r_mem_we <= w_grant_b && bus.b_we;
        if (w_grant_a) begin
          r_mem_addr <= bus.a_addr;
          r_mem_ds   <= 2'b11;
        end else if (w_grant_b) begin
          r_mem_addr <= bus.b_addr;
          r_mem_din  <= bus.b_din;
          r_mem_ds   <= bus.b_ds;
        end
      end
    end
  end

  assign bus.mem_sync = r_sync;
  assign bus.mem_oe   = r_mem_oe;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.mem_ds   = r_mem_ds;
  assign bus.a_ack    = r_a_ack;
  assign bus.b_ack    = r_b_ack;
  assign bus.a_valid  = r_a_valid;
  assign bus.b_valid  = r_b_valid;
  assign bus.a_data   = r_a_data;
  assign bus.b_data   = r_b_data;

endmodule
`default_nettype wire
